memory_store_unit: RTL and testbench

Store-side counterpart of the writeback load filter. It takes a store instruction in the memory stage (SB, SH, SW, SWL, SWR), forms the word-aligned bus address, byte enables and lane-aligned write data, and drives one Avalon-style write with waitrequest handshaking. It stalls the pipeline until the write is accepted, and flags misaligned SH/SW as an address error without touching the bus.

---
 rtl/memory_store_unit_pkg.sv | 29 ++
 rtl/memory_store_unit_lane_formatter.sv | 77 +++++++
 rtl/memory_store_unit.sv | 183 ++++++++++++++++++
 tb/tb_memory_store_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_store_unit_pkg.sv
// ----------------------------------------------------------------------------
// memory_store_unit_pkg
// Shared definitions for the store path of the memory stage:
//   - store opcode constants (shared with the instruction decoder)
//   - FSM state enum for the store unit (IDLE / WRITE)
//   - 4-bit byte-enable type
//   - helper to recognise a store opcode
// ----------------------------------------------------------------------------
package memory_store_unit_pkg;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  typedef logic [3:0] byteen_t;

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SWL) ||
           (op == OP_SW) || (op == OP_SWR);
  endfunction

endpackage

// File: rtl/memory_store_unit_lane_formatter.sv
// ----------------------------------------------------------------------------
// store_lane_formatter
// Purely combinational lane steering for stores. Maps the opcode, the byte
// offset within the word and the rt data onto little-endian bus lanes.
// Ports:
//   i_op           store opcode
//   i_k            byte offset address[1:0]
//   i_rt           rt store data
//   o_is_store     opcode is one of SB/SH/SW/SWL/SWR
//   o_byteenable   active lanes (0 when misaligned or not a store)
//   o_writedata    lane-aligned data, unused lanes zero
//   o_misaligned   SH with odd offset, or SW with non-zero offset
// ----------------------------------------------------------------------------
module store_lane_formatter
  import memory_store_unit_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_k,
  input  logic [31:0] i_rt,
  output logic        o_is_store,
  output byteen_t     o_byteenable,
  output logic [31:0] o_writedata,
  output logic        o_misaligned
);

  // Bit shift that moves lane 0 up to lane k.
  logic [4:0] w_shift_up;
  // SWL writes the high end of rt into the low lanes: shift down by 3-k lanes.
  logic [4:0] w_shift_dn;

  assign w_shift_up = {i_k, 3'b000};
  assign w_shift_dn = {~i_k, 3'b000};

  always_comb begin
    o_is_store   = is_store_op(i_op);
    o_byteenable = 4'b0000;
    o_writedata  = 32'h0000_0000;
    o_misaligned = 1'b0;
    case (i_op)
      OP_SB: begin
        o_byteenable = 4'b0001 << i_k;
        o_writedata  = {24'h00_0000, i_rt[7:0]} << w_shift_up;
      end
      OP_SH: begin
        if (i_k[0]) begin
          o_misaligned = 1'b1;
        end else if (i_k[1]) begin
          o_byteenable = 4'b1100;
          o_writedata  = {i_rt[15:0], 16'h0000};
        end else begin
          o_byteenable = 4'b0011;
          o_writedata  = {16'h0000, i_rt[15:0]};
        end
      end
      OP_SW: begin
        if (i_k != 2'b00) begin
          o_misaligned = 1'b1;
        end else begin
          o_byteenable = 4'b1111;
          o_writedata  = i_rt;
        end
      end
      OP_SWL: begin
        o_byteenable = 4'b1111 >> ~i_k;
        o_writedata  = i_rt >> w_shift_dn;
      end
      OP_SWR: begin
        o_byteenable = 4'b1111 << i_k;
        o_writedata  = i_rt << w_shift_up;
      end
      default: begin
        o_byteenable = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/memory_store_unit.sv
// ----------------------------------------------------------------------------
// memory_store_unit
// Memory-stage store engine. Accepts one store at a time, issues a single
// Avalon-style write with waitrequest handshaking and holds the pipeline
// until the write is accepted. Misaligned SH/SW raise an address error and
// never reach the bus. An optional wait limit aborts a stuck write.
//
// Bus handshake: data_write is raised the cycle after a store is accepted
// and, with data_address/data_writedata/data_byteenable, is held constant
// until a cycle in which data_waitrequest is low; that cycle completes the
// transfer (store_done high) and the bus drops data_write at the next edge.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   store_valid_memory    valid instruction in memory stage
//   op_memory             its opcode
//   address_memory        effective byte address
//   src_B_memory          rt store data
//   stall_memory          pipeline hold (combinational)
//   store_done            write accepted (same cycle as waitrequest low)
//   address_error         one-cycle pulse after a misaligned SH/SW
//   bad_address           last faulting byte address
//   bus_timeout           one-cycle pulse after a write is aborted
//   data_address          word-aligned bus address
//   data_write            write strobe
//   data_writedata        lane-aligned data
//   data_byteenable       active lanes
//   data_waitrequest      slave not ready
//   o_dbg_state           current FSM state
// ----------------------------------------------------------------------------
module memory_store_unit
  import memory_store_unit_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        store_valid_memory,
  input  logic [5:0]  op_memory,
  input  logic [31:0] address_memory,
  input  logic [31:0] src_B_memory,
  output logic        stall_memory,
  output logic        store_done,
  output logic        address_error,
  output logic [31:0] bad_address,
  output logic        bus_timeout,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic [31:0] data_writedata,
  output byteen_t     data_byteenable,
  input  logic        data_waitrequest,
  output state_e      o_dbg_state
);

  localparam bit          LP_LIMITED   = (STALL_LIMIT != 0);
  localparam logic [31:0] LP_LAST_WAIT = LP_LIMITED ? 32'(STALL_LIMIT - 1) : 32'd0;

  state_e      r_state;
  state_e      w_state_next;

  logic        r_data_write;
  logic [31:0] r_data_address;
  logic [31:0] r_data_writedata;
  byteen_t     r_data_byteenable;
  logic        r_address_error;
  logic [31:0] r_bad_address;
  logic        r_bus_timeout;
  logic [31:0] r_wait_cnt;

  logic        w_is_store;
  byteen_t     w_byteenable;
  logic [31:0] w_writedata;
  logic        w_misaligned;

  logic        w_accept;
  logic        w_misalign_evt;
  logic        w_done;
  logic        w_timeout;
  logic        w_stall;
  logic        w_limit_hit;

  store_lane_formatter u_fmt (
    .i_op         (op_memory),
    .i_k          (address_memory[1:0]),
    .i_rt         (src_B_memory),
    .o_is_store   (w_is_store),
    .o_byteenable (w_byteenable),
    .o_writedata  (w_writedata),
    .o_misaligned (w_misaligned)
  );

  // The counter holds the number of waitrequest cycles already spent in this
  // WRITE; the abort happens on the STALL_LIMIT-th such cycle.
  assign w_limit_hit = LP_LIMITED && (r_wait_cnt == LP_LAST_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_accept       = 1'b0;
    w_misalign_evt = 1'b0;
    w_done         = 1'b0;
    w_timeout      = 1'b0;
    w_stall        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (store_valid_memory && w_is_store) begin
          if (w_misaligned) begin
            w_misalign_evt = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_stall      = 1'b1;
            w_state_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (!data_waitrequest) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_limit_hit) begin
          // Release the pipeline in the abort cycle; the pulse follows.
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_write      <= 1'b0;
      r_data_address    <= 32'h0000_0000;
      r_data_writedata  <= 32'h0000_0000;
      r_data_byteenable <= 4'b0000;
      r_address_error   <= 1'b0;
      r_bad_address     <= 32'h0000_0000;
      r_bus_timeout     <= 1'b0;
      r_wait_cnt        <= 32'd0;
    end else begin
      r_address_error <= w_misalign_evt;
      r_bus_timeout   <= w_timeout;
      if (w_misalign_evt) begin
        r_bad_address <= address_memory;
      end
      if (w_accept) begin
        r_data_write      <= 1'b1;
        r_data_address    <= {address_memory[31:2], 2'b00};
        r_data_writedata  <= w_writedata;
        r_data_byteenable <= w_byteenable;
        r_wait_cnt        <= 32'd0;
      end else if (w_done || w_timeout) begin
        r_data_write <= 1'b0;
      end else if ((r_state == ST_WRITE) && (r_wait_cnt != 32'hFFFF_FFFF)) begin
        // Saturate so an unlimited wait never wraps.
        r_wait_cnt <= r_wait_cnt + 32'd1;
      end
    end
  end

  assign stall_memory    = w_stall & ~reset;
  assign store_done      = w_done;
  assign address_error   = r_address_error;
  assign bad_address     = r_bad_address;
  assign bus_timeout     = r_bus_timeout;
  assign data_address    = r_data_address;
  assign data_write      = r_data_write;
  assign data_writedata  = r_data_writedata;
  assign data_byteenable = r_data_byteenable;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_memory_store_unit.sv
module tb_memory_store_unit;
  import memory_store_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // shared stimulus
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] rt;

  // unlimited-wait instance
  logic        valid, wr;
  logic        stall, done, aerr, btmo, dwrite;
  logic [31:0] badaddr, daddr, wdata;
  byteen_t     be;
  state_e      dbg;

  // STALL_LIMIT=3 instance
  logic        valid_l, wr_l;
  logic        l_stall, l_done, l_aerr, l_btmo, l_dwrite;
  logic [31:0] l_badaddr, l_daddr, l_wdata;
  byteen_t     l_be;
  state_e      l_dbg;

  memory_store_unit #(.STALL_LIMIT(0)) dut (
    .clk(clk), .reset(reset), .store_valid_memory(valid), .op_memory(op),
    .address_memory(addr), .src_B_memory(rt), .stall_memory(stall),
    .store_done(done), .address_error(aerr), .bad_address(badaddr),
    .bus_timeout(btmo), .data_address(daddr), .data_write(dwrite),
    .data_writedata(wdata), .data_byteenable(be), .data_waitrequest(wr),
    .o_dbg_state(dbg)
  );

  memory_store_unit #(.STALL_LIMIT(3)) dut_lim (
    .clk(clk), .reset(reset), .store_valid_memory(valid_l), .op_memory(op),
    .address_memory(addr), .src_B_memory(rt), .stall_memory(l_stall),
    .store_done(l_done), .address_error(l_aerr), .bad_address(l_badaddr),
    .bus_timeout(l_btmo), .data_address(l_daddr), .data_write(l_dwrite),
    .data_writedata(l_wdata), .data_byteenable(l_be), .data_waitrequest(wr_l),
    .o_dbg_state(l_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [35:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [5:0] o, input logic [31:0] a,
                       input logic [31:0] d);
    valid = v;
    op    = o;
    addr  = a;
    rt    = d;
  endtask

  // ---------------- vector table ----------------
  localparam logic [1:0] K_STORE = 2'd0;
  localparam logic [1:0] K_ERR   = 2'd1;
  localparam logic [1:0] K_IGN   = 2'd2;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [1:0]  kind;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] k, input logic [3:0] b, input logic [31:0] w);
    vec_t v;
    v.op = o; v.addr = a; v.rt = d; v.kind = k; v.be = b; v.wd = w;
    return v;
  endfunction

  logic [31:0] last_bad;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [35:0] e;

    vecs[0]  = mk(OP_SB,  32'h0000_1003, 32'h0000_00AB, K_STORE, 4'b1000, 32'hAB00_0000);
    vecs[1]  = mk(OP_SB,  32'h0000_1001, 32'h1234_5678, K_STORE, 4'b0010, 32'h0000_7800);
    vecs[2]  = mk(OP_SH,  32'h0000_3002, 32'hCAFE_BEEF, K_STORE, 4'b1100, 32'hBEEF_0000);
    vecs[3]  = mk(OP_SH,  32'h0000_3000, 32'hCAFE_BEEF, K_STORE, 4'b0011, 32'h0000_BEEF);
    vecs[4]  = mk(OP_SW,  32'h0000_4000, 32'hDEAD_BEEF, K_STORE, 4'b1111, 32'hDEAD_BEEF);
    vecs[5]  = mk(OP_SWR, 32'h0000_2001, 32'h1122_3344, K_STORE, 4'b1110, 32'h2233_4400);
    vecs[6]  = mk(OP_SWR, 32'h0000_2003, 32'h1122_3344, K_STORE, 4'b1000, 32'h4400_0000);
    vecs[7]  = mk(OP_SWL, 32'h0000_2002, 32'h1122_3344, K_STORE, 4'b0111, 32'h0011_2233);
    vecs[8]  = mk(OP_SWL, 32'h0000_2000, 32'h1122_3344, K_STORE, 4'b0001, 32'h0000_0011);
    vecs[9]  = mk(OP_SWL, 32'h0000_2003, 32'h1122_3344, K_STORE, 4'b1111, 32'h1122_3344);
    vecs[10] = mk(OP_SH,  32'h0000_3001, 32'hCAFE_BEEF, K_ERR,   4'b0000, 32'h0);
    vecs[11] = mk(OP_SW,  32'h0000_4002, 32'hCAFE_BEEF, K_ERR,   4'b0000, 32'h0);
    vecs[12] = mk(6'b100011, 32'h0000_5000, 32'hCAFE_BEEF, K_IGN, 4'b0000, 32'h0);

    // ---- reset: a valid store presented during reset must not stall ----
    reset = 1'b1; wr = 1'b0; valid_l = 1'b0; wr_l = 1'b0;
    drive(1'b1, OP_SW, 32'h0000_4000, 32'h1);
    last_bad = 32'h0;
    tick(); tick(); mid();
    chk("reset_stall",   32'(stall), 32'd0);
    chk("reset_write",   32'(dwrite), 32'd0);
    chk("reset_done",    32'(done), 32'd0);
    chk("reset_badaddr", badaddr, 32'h0);
    chk("reset_state",   32'(dbg), 32'(ST_IDLE));
    tick();
    reset = 1'b0;
    drive(1'b0, 6'd0, 32'h0, 32'h0);

    // ---- table-driven single stores, waitrequest low ----
    for (int i = 0; i < NV; i++) begin
      tick();
      drive(1'b1, vecs[i].op, vecs[i].addr, vecs[i].rt);
      if (vecs[i].kind == K_STORE) exp_q.push_back({vecs[i].be, vecs[i].wd});
      mid();
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].kind == K_STORE));
      chk($sformatf("v%0d_done0", i), 32'(done), 32'd0);
      tick();
      drive(1'b0, 6'd0, 32'h0, 32'h0);
      mid();
      if (vecs[i].kind == K_STORE) begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d_write", i), 32'(dwrite), 32'd1);
        chk($sformatf("v%0d_addr", i),  daddr, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_be", i),    32'(be), 32'(e[35:32]));
        chk($sformatf("v%0d_wd", i),    wdata, e[31:0]);
        chk($sformatf("v%0d_done", i),  32'(done), 32'd1);
        chk($sformatf("v%0d_stall1", i), 32'(stall), 32'd0);
      end else if (vecs[i].kind == K_ERR) begin
        last_bad = vecs[i].addr;
        chk($sformatf("v%0d_aerr", i),  32'(aerr), 32'd1);
        chk($sformatf("v%0d_bad", i),   badaddr, vecs[i].addr);
        chk($sformatf("v%0d_nowr", i),  32'(dwrite), 32'd0);
        chk($sformatf("v%0d_stall1", i), 32'(stall), 32'd0);
      end else begin
        chk($sformatf("v%0d_nowr", i),  32'(dwrite), 32'd0);
        chk($sformatf("v%0d_noerr", i), 32'(aerr), 32'd0);
        chk($sformatf("v%0d_stall1", i), 32'(stall), 32'd0);
      end
      tick();
      mid();
      chk($sformatf("v%0d_idle_wr", i),   32'(dwrite), 32'd0);
      chk($sformatf("v%0d_idle_done", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_idle_aerr", i), 32'(aerr), 32'd0);
    end

    // ---- SW with 5 waitrequest cycles, then back-to-back SB ----
    tick();
    drive(1'b1, OP_SW, 32'h0000_4000, 32'hA5A5_0F0F);
    wr = 1'b1;
    mid();
    chk("wait_accept_stall", 32'(stall), 32'd1);
    tick();
    // Inputs are ignored during WRITE; this SB is taken once IDLE returns.
    drive(1'b1, OP_SB, 32'h0000_8002, 32'h0000_0055);
    for (int c = 0; c < 5; c++) begin
      mid();
      chk($sformatf("wait%0d_write", c), 32'(dwrite), 32'd1);
      chk($sformatf("wait%0d_stall", c), 32'(stall), 32'd1);
      chk($sformatf("wait%0d_addr", c),  daddr, 32'h0000_4000);
      chk($sformatf("wait%0d_wd", c),    wdata, 32'hA5A5_0F0F);
      chk($sformatf("wait%0d_be", c),    32'(be), 32'hF);
      chk($sformatf("wait%0d_done", c),  32'(done), 32'd0);
      chk($sformatf("wait%0d_state", c), 32'(dbg), 32'(ST_WRITE));
      tick();
    end
    wr = 1'b0;
    mid();
    chk("wait_done",  32'(done), 32'd1);
    chk("wait_stall", 32'(stall), 32'd0);
    tick();
    mid();
    chk("b2b_accept_stall", 32'(stall), 32'd1);
    chk("b2b_gap_write",    32'(dwrite), 32'd0);
    tick();
    drive(1'b0, 6'd0, 32'h0, 32'h0);
    mid();
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_addr", daddr, 32'h0000_8000);
    chk("b2b_be",   32'(be), 32'h4);
    chk("b2b_wd",   wdata, 32'h0055_0000);
    tick();
    mid();
    chk("b2b_idle_write", 32'(dwrite), 32'd0);
    chk("bad_addr_hold",  badaddr, last_bad);

    // ---- STALL_LIMIT=3 timeout ----
    tick();
    valid_l = 1'b1; op = OP_SW; addr = 32'h0000_6000; rt = 32'h0000_0001; wr_l = 1'b1;
    mid();
    chk("to_accept_stall", 32'(l_stall), 32'd1);
    tick();
    valid_l = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mid();
      chk($sformatf("to_w%0d_write", c), 32'(l_dwrite), 32'd1);
      chk($sformatf("to_w%0d_stall", c), 32'(l_stall), 32'd1);
      tick();
    end
    mid();
    chk("to_last_write", 32'(l_dwrite), 32'd1);
    chk("to_last_stall", 32'(l_stall), 32'd0);
    chk("to_last_done",  32'(l_done), 32'd0);
    tick();
    mid();
    chk("to_pulse",   32'(l_btmo), 32'd1);
    chk("to_dropped", 32'(l_dwrite), 32'd0);
    chk("to_nodone",  32'(l_done), 32'd0);
    chk("to_idle",    32'(l_dbg), 32'(ST_IDLE));
    tick();
    wr_l = 1'b0;
    mid();
    chk("to_pulse_end", 32'(l_btmo), 32'd0);
    chk("to_nodone2",   32'(l_done), 32'd0);
    chk("nolimit_no_to", 32'(btmo), 32'd0);

    // ---- reset asserted mid-WRITE, then a clean SW ----
    tick();
    drive(1'b1, OP_SW, 32'h0000_4000, 32'h7777_7777);
    wr = 1'b1;
    mid();
    chk("rst_accept_stall", 32'(stall), 32'd1);
    tick();
    drive(1'b0, 6'd0, 32'h0, 32'h0);
    mid();
    chk("rst_pre_write", 32'(dwrite), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_write_drop", 32'(dwrite), 32'd0);
    chk("rst_no_done",    32'(done), 32'd0);
    chk("rst_no_stall",   32'(stall), 32'd0);
    tick();
    reset = 1'b0;
    wr = 1'b0;
    tick();
    drive(1'b1, OP_SW, 32'h0000_5000, 32'h0BAD_F00D);
    mid();
    chk("post_rst_stall", 32'(stall), 32'd1);
    tick();
    drive(1'b0, 6'd0, 32'h0, 32'h0);
    mid();
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_addr", daddr, 32'h0000_5000);
    chk("post_rst_wd",   wdata, 32'h0BAD_F00D);
    chk("post_rst_be",   32'(be), 32'hF);
    tick();
    mid();
    chk("post_rst_idle", 32'(dwrite), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
